// File: rtl/ucsbece154b_victim_cache_wb.sv
// Write-back set-associative victim cache between the L1 D$ and the L2/memory port.
// Zero-latency lookup; dirty victims leave through a one-entry valid/ready writeback buffer.
module ucsbece154b_victim_cache_wb #(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int NR_SETS    = 1,
  parameter int NR_WAYS    = 4,
  parameter int REPL_FIFO  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  take_i,
  output logic                  hit_o,
  output logic [LINE_WIDTH-1:0] rdata_o,
  output logic                  rdirty_o,
  input  logic                  we_i,
  output logic                  wready_o,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  input  logic                  wdirty_i,
  output logic                  evict_valid_o,
  input  logic                  evict_ready_i,
  output logic [ADDR_WIDTH-1:0] evict_addr_o,
  output logic [LINE_WIDTH-1:0] evict_data_o
);
  localparam int OFF  = $clog2(LINE_WIDTH / 8);
  localparam int IDX  = (NR_SETS > 1) ? $clog2(NR_SETS) : 0;
  localparam int TAGW = ADDR_WIDTH - OFF - IDX;
  localparam int SW   = (NR_SETS > 1) ? IDX : 1;
  localparam int AW   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
  localparam int NE   = NR_SETS * NR_WAYS;
  localparam int PW   = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_n;
  logic [PW-1:0]         r_ptr, w_ptr_n;
  logic                  r_valid [0:NE-1];
  logic                  r_dirty [0:NE-1];
  logic [AW-1:0]         r_age   [0:NE-1];
  logic [TAGW-1:0]       r_tag   [0:NE-1];
  logic [LINE_WIDTH-1:0] r_data  [0:NE-1];
  logic                  w_valid_n [0:NE-1];
  logic                  w_dirty_n [0:NE-1];
  logic [AW-1:0]         w_age_n   [0:NE-1];
  logic                  r_ev_vld;
  logic [ADDR_WIDTH-1:0] r_ev_addr, w_ld_addr, w_vaddr;
  logic [LINE_WIDTH-1:0] r_ev_data, w_ld_data, w_vdata;

  logic [SW-1:0]   w_rset, w_wset;
  logic [TAGW-1:0] w_rtag, w_wtag;
  logic [NE-1:0]   w_rsel, w_wsel, w_vinv_sel, w_vage_sel, w_vsel, w_wtgt, w_wr;
  logic [AW-1:0]   w_vbest, w_rold, w_wold;
  logic            w_idle, w_rmatch, w_wmatch, w_vinv, w_vhave, w_vd, w_acc, w_ld, w_adv;

  function automatic logic [ADDR_WIDTH-1:0] f_line_addr(input logic [TAGW-1:0] tag, input int set);
    return (ADDR_WIDTH'(tag) << (OFF + IDX)) | (ADDR_WIDTH'(set) << OFF);
  endfunction

  assign w_rset = (NR_SETS > 1) ? SW'(raddr_i >> OFF) : '0;
  assign w_wset = (NR_SETS > 1) ? SW'(waddr_i >> OFF) : '0;
  assign w_rtag = TAGW'(raddr_i >> (OFF + IDX));
  assign w_wtag = TAGW'(waddr_i >> (OFF + IDX));

  assign w_idle        = (r_state == S_IDLE);
  assign hit_o         = en_i && w_idle && w_rmatch;
  assign wready_o      = en_i && w_idle && !r_ev_vld;
  assign w_acc         = we_i && wready_o;
  assign flush_done_o  = (r_state == S_DONE);
  assign evict_valid_o = r_ev_vld;
  assign evict_addr_o  = r_ev_addr;
  assign evict_data_o  = r_ev_data;

  always_comb begin
    w_rmatch = 1'b0;
    w_rsel   = '0;
    rdata_o  = '0;
    rdirty_o = 1'b0;
    for (int e = 0; e < NE; e++) begin
      if (!w_rmatch && (e / NR_WAYS) == int'(w_rset) && r_valid[e] && r_tag[e] == w_rtag) begin
        w_rmatch  = 1'b1;
        w_rsel[e] = 1'b1;
        rdata_o   = r_data[e];
        rdirty_o  = r_dirty[e];
      end
    end
  end

  // Write hit and victim selection both look only at pre-cycle state.
  always_comb begin
    w_wmatch   = 1'b0;
    w_wsel     = '0;
    w_vinv     = 1'b0;
    w_vinv_sel = '0;
    w_vhave    = 1'b0;
    w_vbest    = '0;
    w_vage_sel = '0;
    for (int e = 0; e < NE; e++) begin
      if ((e / NR_WAYS) == int'(w_wset)) begin
        if (!w_wmatch && r_valid[e] && r_tag[e] == w_wtag) begin
          w_wmatch  = 1'b1;
          w_wsel[e] = 1'b1;
        end
        if (!w_vinv && !r_valid[e]) begin
          w_vinv        = 1'b1;
          w_vinv_sel[e] = 1'b1;
        end
        if (!w_vhave || r_age[e] > w_vbest) begin
          w_vhave       = 1'b1;
          w_vbest       = r_age[e];
          w_vage_sel    = '0;
          w_vage_sel[e] = 1'b1;
        end
      end
    end
    w_vsel  = w_vinv ? w_vinv_sel : w_vage_sel;
    w_wtgt  = w_wmatch ? w_wsel : w_vsel;
    w_vd    = 1'b0;
    w_vaddr = '0;
    w_vdata = '0;
    for (int e = 0; e < NE; e++) begin
      if (w_vsel[e]) begin
        w_vd    = r_valid[e] && r_dirty[e];
        w_vaddr = f_line_addr(r_tag[e], e / NR_WAYS);
        w_vdata = r_data[e];
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_valid_n = r_valid;
    w_dirty_n = r_dirty;
    w_age_n   = r_age;
    w_wr      = '0;
    w_ld      = 1'b0;
    w_ld_addr = '0;
    w_ld_data = '0;
    w_rold    = '0;
    w_wold    = '0;
    w_adv     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (hit_o) begin
          for (int e = 0; e < NE; e++) begin
            if (w_rsel[e]) begin
              w_rold = r_age[e];
              if (take_i) begin
                w_valid_n[e] = 1'b0;
                w_dirty_n[e] = 1'b0;
              end
            end
          end
          if (!take_i && REPL_FIFO == 0) begin
            for (int e = 0; e < NE; e++) begin
              if ((e / NR_WAYS) == int'(w_rset)) begin
                if (w_rsel[e]) w_age_n[e] = '0;
                else if (r_age[e] < w_rold) w_age_n[e] = r_age[e] + 1'b1;
              end
            end
          end
        end
        // The write is layered on top of the read update so it always wins.
        if (w_acc) begin
          if (!w_wmatch && w_vd) begin
            w_ld      = 1'b1;
            w_ld_addr = w_vaddr;
            w_ld_data = w_vdata;
          end
          for (int e = 0; e < NE; e++) begin
            if (w_wtgt[e]) begin
              w_wold       = w_age_n[e];
              w_valid_n[e] = 1'b1;
              w_dirty_n[e] = (w_wmatch && r_dirty[e]) || wdirty_i;
              w_wr[e]      = 1'b1;
            end
          end
          if (!w_wmatch || REPL_FIFO == 0) begin
            for (int e = 0; e < NE; e++) begin
              if ((e / NR_WAYS) == int'(w_wset)) begin
                if (w_wtgt[e]) w_age_n[e] = '0;
                else if (w_age_n[e] < w_wold) w_age_n[e] = w_age_n[e] + 1'b1;
              end
            end
          end
        end
        if (flush_i && en_i) begin
          w_state_n = S_WALK;
          w_ptr_n   = '0;
        end
      end
      S_WALK: begin
        for (int e = 0; e < NE; e++) begin
          if (e == int'(r_ptr)) begin
            if (r_valid[e] && r_dirty[e]) begin
              if (!r_ev_vld) begin
                w_ld         = 1'b1;
                w_ld_addr    = f_line_addr(r_tag[e], e / NR_WAYS);
                w_ld_data    = r_data[e];
                w_valid_n[e] = 1'b0;
                w_dirty_n[e] = 1'b0;
                w_adv        = 1'b1;
              end
            end else begin
              w_valid_n[e] = 1'b0;
              w_dirty_n[e] = 1'b0;
              w_adv        = 1'b1;
            end
          end
        end
        if (w_adv) begin
          if (r_ptr == PW'(NE - 1)) w_state_n = S_DRAIN;
          else w_ptr_n = r_ptr + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!r_ev_vld) w_state_n = S_DONE;
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        for (int e = 0; e < NE; e++) w_age_n[e] = AW'(e % NR_WAYS);
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      for (int e = 0; e < NE; e++) begin
        r_valid[e] <= 1'b0;
        r_dirty[e] <= 1'b0;
        r_age[e]   <= AW'(e % NR_WAYS);
      end
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_valid <= w_valid_n;
      r_dirty <= w_dirty_n;
      r_age   <= w_age_n;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int e = 0; e < NE; e++) begin
      if (w_wr[e]) begin
        r_tag[e]  <= w_wtag;
        r_data[e] <= wdata_i;
      end
    end
  end

  // Loads only happen while the buffer is empty, so load and drain never collide.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ev_vld <= 1'b0;
    end else if (w_ld) begin
      r_ev_vld  <= 1'b1;
      r_ev_addr <= w_ld_addr;
      r_ev_data <= w_ld_data;
    end else if (r_ev_vld && evict_ready_i) begin
      r_ev_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ucsbece154b_victim_cache_wb.sv
// Bench for the write-back victim cache: LRU fully-associative instance and a 4-set FIFO instance
// share stimulus; writebacks are checked against an expected-eviction queue.
module tb_ucsbece154b_victim_cache_wb;
  localparam int AW = 56;
  localparam int LW = 128;
  localparam logic [AW-1:0] PARK = 56'hFF_FFFF_FFF0;

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n, en, flush, take, we, wdirty, ev_rdy;
  logic [AW-1:0] raddr, waddr;
  logic [LW-1:0] wdata;

  logic a_done, a_hit, a_rdirty, a_wready, a_evv;
  logic b_done, b_hit, b_rdirty, b_wready, b_evv;
  logic [LW-1:0] a_rdata, b_rdata, a_evd, b_evd;
  logic [AW-1:0] a_eva, b_eva;

  logic sel = 1'b0;
  logic cur_done, cur_hit, cur_rdirty, cur_wready, cur_evv;
  logic [LW-1:0] cur_rdata, cur_evd;
  logic [AW-1:0] cur_eva;

  int  n_chk = 0;
  int  n_err = 0;
  int  done_cnt = 0;
  ev_t sb[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  ucsbece154b_victim_cache_wb dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush), .flush_done_o(a_done),
    .raddr_i(raddr), .take_i(take), .hit_o(a_hit), .rdata_o(a_rdata), .rdirty_o(a_rdirty),
    .we_i(we), .wready_o(a_wready), .waddr_i(waddr), .wdata_i(wdata), .wdirty_i(wdirty),
    .evict_valid_o(a_evv), .evict_ready_i(ev_rdy), .evict_addr_o(a_eva), .evict_data_o(a_evd)
  );

  ucsbece154b_victim_cache_wb #(.NR_SETS(4), .NR_WAYS(4), .REPL_FIFO(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush), .flush_done_o(b_done),
    .raddr_i(raddr), .take_i(take), .hit_o(b_hit), .rdata_o(b_rdata), .rdirty_o(b_rdirty),
    .we_i(we), .wready_o(b_wready), .waddr_i(waddr), .wdata_i(wdata), .wdirty_i(wdirty),
    .evict_valid_o(b_evv), .evict_ready_i(ev_rdy), .evict_addr_o(b_eva), .evict_data_o(b_evd)
  );

  assign cur_done   = sel ? b_done   : a_done;
  assign cur_hit    = sel ? b_hit    : a_hit;
  assign cur_rdata  = sel ? b_rdata  : a_rdata;
  assign cur_rdirty = sel ? b_rdirty : a_rdirty;
  assign cur_wready = sel ? b_wready : a_wready;
  assign cur_evv    = sel ? b_evv    : a_evv;
  assign cur_eva    = sel ? b_eva    : a_eva;
  assign cur_evd    = sel ? b_evd    : a_evd;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {a[31:0], 32'hDEAD_BEEF, ~a[31:0], 32'h1234_5678};
  endfunction

  // Every writeback handshake must match the oldest expected eviction.
  always @(negedge clk) begin
    if (cur_done) done_cnt++;
    if (cur_evv && ev_rdy) begin
      if (sb.size() == 0) begin
        chk("ev_unexpected", 128'(1), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("ev_addr", 128'(cur_eva), 128'(mon_e.a));
        chk("ev_data", cur_evd, mon_e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic dty);
    int n = 0;
    waddr = a; wdata = d; wdirty = dty; we = 1'b1;
    @(negedge clk);
    while (!cur_wready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cur_wready) chk("wr_timeout", 128'(cur_wready), 128'(1));
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic tk, input logic exp_hit,
                    input logic [LW-1:0] exp_d, input logic exp_dirty);
    raddr = a; take = tk;
    @(negedge clk);
    chk(tag, 128'(cur_hit), 128'(exp_hit));
    if (exp_hit) begin
      chk({tag, "_data"}, cur_rdata, exp_d);
      chk({tag, "_dirty"}, 128'(cur_rdirty), 128'(exp_dirty));
    end
    tick();
    raddr = PARK; take = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; take = 1'b0; we = 1'b0; wdirty = 1'b0; ev_rdy = 1'b0;
    raddr = PARK; waddr = '0; wdata = '0;
    do_reset();
    raddr = 56'h0;
    @(negedge clk);
    chk("rst_hit", 128'(a_hit), 128'(0));
    chk("rst_evv", 128'(a_evv), 128'(0));
    chk("rst_done", 128'(a_done), 128'(0));
    chk("rst_wready", 128'(a_wready), 128'(1));
    raddr = PARK;
    tick();

    // LRU replacement: A refreshed, so B is oldest when E arrives.
    wr(56'h100, line_of(56'h100), 1'b0);
    wr(56'h200, line_of(56'h200), 1'b0);
    wr(56'h300, line_of(56'h300), 1'b0);
    wr(56'h400, line_of(56'h400), 1'b0);
    rd("t1_readA", 56'h108, 1'b0, 1'b1, line_of(56'h100), 1'b0);
    wr(56'h500, line_of(56'h500), 1'b0);
    rd("t1_hitA", 56'h100, 1'b0, 1'b1, line_of(56'h100), 1'b0);
    rd("t1_missB", 56'h200, 1'b0, 1'b0, '0, 1'b0);
    rd("t1_hitC", 56'h300, 1'b0, 1'b1, line_of(56'h300), 1'b0);
    rd("t1_hitD", 56'h400, 1'b0, 1'b1, line_of(56'h400), 1'b0);
    rd("t1_hitE", 56'h500, 1'b0, 1'b1, line_of(56'h500), 1'b0);
    chk("t1_evv", 128'(a_evv), 128'(0));
    en = 1'b0; raddr = 56'h100;
    @(negedge clk);
    chk("t1_en_hit", 128'(a_hit), 128'(0));
    chk("t1_en_wready", 128'(a_wready), 128'(0));
    tick();
    en = 1'b1; raddr = PARK;

    // Dirty victim goes to the writeback buffer and blocks inserts until drained.
    do_reset();
    wr(56'h1000, 128'hAA, 1'b1);
    wr(56'h2000, line_of(56'h2000), 1'b0);
    wr(56'h3000, line_of(56'h3000), 1'b0);
    wr(56'h4000, line_of(56'h4000), 1'b0);
    sb.push_back('{a: 56'h1000, d: 128'hAA});
    wr(56'h5000, line_of(56'h5000), 1'b0);
    @(negedge clk);
    chk("t2_evv", 128'(a_evv), 128'(1));
    chk("t2_eva", 128'(a_eva), 128'(56'h1000));
    chk("t2_evd", a_evd, 128'hAA);
    chk("t2_wready0", 128'(a_wready), 128'(0));
    tick();
    @(negedge clk);
    chk("t2_wready0b", 128'(a_wready), 128'(0));
    tick();
    ev_rdy = 1'b1;
    tick();
    ev_rdy = 1'b0;
    @(negedge clk);
    chk("t2_evv_clr", 128'(a_evv), 128'(0));
    chk("t2_wready1", 128'(a_wready), 128'(1));
    tick();

    // Take-hit frees a way; the next insert lands there without eviction.
    rd("t3_take", 56'h2000, 1'b1, 1'b1, line_of(56'h2000), 1'b0);
    rd("t3_gone", 56'h2000, 1'b0, 1'b0, '0, 1'b0);
    wr(56'h6000, line_of(56'h6000), 1'b0);
    @(negedge clk);
    chk("t3_evv", 128'(a_evv), 128'(0));
    tick();
    rd("t3_hit3", 56'h3000, 1'b0, 1'b1, line_of(56'h3000), 1'b0);
    rd("t3_hit4", 56'h4000, 1'b0, 1'b1, line_of(56'h4000), 1'b0);
    rd("t3_hit5", 56'h5000, 1'b0, 1'b1, line_of(56'h5000), 1'b0);
    rd("t3_hit6", 56'h6000, 1'b0, 1'b1, line_of(56'h6000), 1'b0);

    // Concurrent take and write of the same tag: write wins, dirty is kept.
    do_reset();
    wr(56'h7000, line_of(56'h7000), 1'b1);
    raddr = 56'h7000; take = 1'b1;
    waddr = 56'h7000; wdata = 128'hBEEF; wdirty = 1'b0; we = 1'b1;
    @(negedge clk);
    chk("t6_cc_hit", 128'(a_hit), 128'(1));
    chk("t6_cc_wready", 128'(a_wready), 128'(1));
    tick();
    we = 1'b0; take = 1'b0; raddr = PARK;
    rd("t6_same", 56'h7000, 1'b0, 1'b1, 128'hBEEF, 1'b1);

    // Reset in the middle of a stalled flush abandons it.
    wr(56'h8000, line_of(56'h8000), 1'b1);
    wr(56'h9000, line_of(56'h9000), 1'b1);
    done_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    raddr = 56'h9000;
    @(negedge clk);
    chk("t6_walk_evv", 128'(a_evv), 128'(1));
    chk("t6_walk_hit", 128'(a_hit), 128'(0));
    chk("t6_walk_wready", 128'(a_wready), 128'(0));
    raddr = PARK;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_evv", 128'(a_evv), 128'(0));
    repeat (8) tick();
    chk("t6_no_done", 128'(done_cnt), 128'(0));
    rd("t6_miss8", 56'h8000, 1'b0, 1'b0, '0, 1'b0);
    chk("t6_wready", 128'(a_wready), 128'(1));

    // FIFO: repeated hits on A do not save it from eviction.
    sel = 1'b1;
    do_reset();
    ev_rdy = 1'b1;
    wr(56'h100, 128'hA1, 1'b1);
    wr(56'h200, line_of(56'h200), 1'b0);
    wr(56'h300, line_of(56'h300), 1'b0);
    wr(56'h400, line_of(56'h400), 1'b0);
    rd("t4_readA0", 56'h100, 1'b0, 1'b1, 128'hA1, 1'b1);
    rd("t4_readA1", 56'h100, 1'b0, 1'b1, 128'hA1, 1'b1);
    rd("t4_readA2", 56'h100, 1'b0, 1'b1, 128'hA1, 1'b1);
    sb.push_back('{a: 56'h100, d: 128'hA1});
    wr(56'h500, line_of(56'h500), 1'b0);
    repeat (2) tick();
    ev_rdy = 1'b0;
    rd("t4_missA", 56'h100, 1'b0, 1'b0, '0, 1'b0);
    rd("t4_hitB", 56'h200, 1'b0, 1'b1, line_of(56'h200), 1'b0);
    rd("t4_hitE", 56'h500, 1'b0, 1'b1, line_of(56'h500), 1'b0);

    // Flush across sets drains set 1 before set 3, then pulses done once.
    do_reset();
    wr(56'h1010, 128'h51, 1'b1);
    wr(56'h2020, line_of(56'h2020), 1'b0);
    wr(56'h3030, 128'h53, 1'b1);
    sb.push_back('{a: 56'h1010, d: 128'h51});
    sb.push_back('{a: 56'h3030, d: 128'h53});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    raddr = 56'h3030;
    @(negedge clk);
    chk("t5_stall_evv", 128'(b_evv), 128'(1));
    chk("t5_stall_eva", 128'(b_eva), 128'(56'h1010));
    chk("t5_stall_hit", 128'(b_hit), 128'(0));
    chk("t5_no_done_yet", 128'(done_cnt), 128'(0));
    raddr = PARK;
    tick();
    ev_rdy = 1'b1;
    for (int n = 0; n < 200 && done_cnt == 0; n++) tick();
    chk("t5_done_seen", 128'(done_cnt), 128'(1));
    chk("t5_sb_at_done", 128'(sb.size()), 128'(0));
    repeat (3) tick();
    ev_rdy = 1'b0;
    chk("t5_done_once", 128'(done_cnt), 128'(1));
    rd("t5_miss1", 56'h1010, 1'b0, 1'b0, '0, 1'b0);
    rd("t5_miss2", 56'h2020, 1'b0, 1'b0, '0, 1'b0);
    rd("t5_miss3", 56'h3030, 1'b0, 1'b0, '0, 1'b0);
    chk("t5_wready", 128'(b_wready), 128'(1));

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
